// File: rtl/seq_logic_unit.sv
// seq_logic_unit: slice-serial bitwise logic unit.
// Accepts two WIDTH-bit operands plus a 3-bit opcode over a valid/ready handshake.
// Evaluates SLICE bits per cycle, starting with the LSB slice.
// Holds the registered result with zero/negative flags until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request (high only in IDLE)
//   op         opcode: AND, OR, XOR, NAND, NOR, XNOR, NOT a, PASS a
//   a, b       operands (b ignored for NOT/PASS)
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   out        result register
//   zero       out == 0
//   neg        out[WIDTH-1]
module seq_logic_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg
);

    // SLICE is expected to divide WIDTH evenly.
    localparam int unsigned N  = WIDTH / SLICE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  result_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              zero_q;
    logic              neg_q;

    logic [31:0]       off_c;
    logic [SLICE-1:0]  a_sl_c;
    logic [SLICE-1:0]  b_sl_c;
    logic [SLICE-1:0]  slice_res_c;
    logic [WIDTH-1:0]  slice_mask_c;
    logic [WIDTH-1:0]  result_d;

    // Select the active slice of the captured operands.
    always_comb begin
        off_c  = 32'(cnt_q) * SLICE;
        a_sl_c = SLICE'(a_q >> off_c);
        b_sl_c = SLICE'(b_q >> off_c);
    end

    // Bitwise function on one slice.
    always_comb begin
        slice_res_c = '0;
        case (op_q)
            OP_AND:  slice_res_c = a_sl_c & b_sl_c;
            OP_OR:   slice_res_c = a_sl_c | b_sl_c;
            OP_XOR:  slice_res_c = a_sl_c ^ b_sl_c;
            OP_NAND: slice_res_c = ~(a_sl_c & b_sl_c);
            OP_NOR:  slice_res_c = ~(a_sl_c | b_sl_c);
            OP_XNOR: slice_res_c = ~(a_sl_c ^ b_sl_c);
            OP_NOTA: slice_res_c = ~a_sl_c;
            OP_PASS: slice_res_c = a_sl_c;
            default: slice_res_c = '0;
        endcase
    end

    // Merge the new slice into its bit range of the result.
    always_comb begin
        slice_mask_c = WIDTH'({SLICE{1'b1}}) << off_c;
        result_d     = (result_q & ~slice_mask_c) | ((WIDTH'(slice_res_c) << off_c) & slice_mask_c);
    end

    // Control FSM and datapath registers; flags track the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q         <= a;
                        b_q         <= b;
                        op_q        <= op;
                        cnt_q       <= '0;
                        result_q    <= '0;
                        zero_q      <= 1'b1;
                        neg_q       <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    result_q <= result_d;
                    zero_q   <= (result_d == '0);
                    neg_q    <= result_d[WIDTH-1];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = result_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
module tb_seq_logic_unit;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance 1: WIDTH=16, SLICE=4
    logic        in_valid, in_ready, out_valid, out_ready, zero, neg;
    logic [2:0]  op;
    logic [15:0] a, b, out;

    // Instance 2: WIDTH=16, SLICE=16
    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, neg2;
    logic [2:0]  op2;
    logic [15:0] a2, b2, out2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_logic_unit #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero), .neg(neg)
    );

    seq_logic_unit #(.WIDTH(16), .SLICE(16)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .op(op2), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out(out2), .zero(zero2), .neg(neg2)
    );

    // Whole-word reference of the opcode table.
    function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance 1, wait for the result, leave it in DONE.
    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, output int lat);
        in_valid = 1'b1; op = o; a = x; b = y;
        tick();
        in_valid = 1'b0;
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [15:0] sweep_exp [8];
    logic [15:0] exp_v;
    int          lat;

    initial begin
        sweep_exp[0] = 16'h0350; sweep_exp[1] = 16'hCFFA;
        sweep_exp[2] = 16'hCCAA; sweep_exp[3] = 16'hFCAF;
        sweep_exp[4] = 16'h3005; sweep_exp[5] = 16'h3355;
        sweep_exp[6] = 16'h3CA5; sweep_exp[7] = 16'hC35A;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; op2 = '0; a2 = '0; b2 = '0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out", 32'(out), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_neg", 32'(neg), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic OR
        issue(3'b001, 16'hF0F0, 16'h0F0F, lat);
        check("or_latency", 32'(lat), 32'd4);
        check("or_out", 32'(out), 32'h0000FFFF);
        check("or_zero", 32'(zero), 32'd0);
        check("or_neg", 32'(neg), 32'd1);
        drain();
        check("idle_after_drain", 32'(in_ready), 32'd1);

        // Opcode sweep against the fixed table and the model
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 16'hC35A, 16'h0FF0, lat);
            check($sformatf("sweep_tbl_op%0d", i), 32'(out), 32'(sweep_exp[i]));
            check($sformatf("sweep_ref_op%0d", i), 32'(out), 32'(ref_op(3'(i), 16'hC35A, 16'h0FF0)));
            drain();
        end

        // Backpressure: hold the result, ignore in_valid while DONE
        issue(3'b100, 16'hFFFF, 16'h1234, lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1; op = 3'b001; a = 16'h5555; b = 16'hAAAA;
            end else begin
                in_valid = 1'b0;
            end
            check("bp_out", 32'(out), 32'd0);
            check("bp_zero", 32'(zero), 32'd1);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("bp_out_end", 32'(out), 32'd0);
        drain();
        issue(3'b010, 16'h1234, 16'hFFFF, lat);
        check("bp_next_out", 32'(out), 32'h0000EDCB);
        drain();

        // Operand isolation during BUSY
        in_valid = 1'b1; op = 3'b000; a = 16'hFFFF; b = 16'hAAAA;
        tick();
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; op = 3'b111;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("iso_latency", 32'(lat), 32'd4);
        check("iso_out", 32'(out), 32'h0000AAAA);
        drain();

        // Reset in the middle of an operation
        in_valid = 1'b1; op = 3'b001; a = 16'hFFFF; b = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_zero", 32'(zero), 32'd1);
        issue(3'b010, 16'h00FF, 16'h0F0F, lat);
        check("midrst_xor", 32'(out), 32'h00000FF0);
        drain();

        // Randomized requests against the model
        for (int i = 0; i < 25; i++) begin
            logic [2:0]  ro;
            logic [15:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'h0000; rb = 16'h0000; ro = 3'b001; end
            exp_v = ref_op(ro, ra, rb);
            issue(ro, ra, rb, lat);
            check("rnd_latency", 32'(lat), 32'd4);
            check("rnd_out", 32'(out), 32'(exp_v));
            check("rnd_zero", 32'(zero), 32'(exp_v == 16'h0000));
            check("rnd_neg", 32'(neg), 32'(exp_v[15]));
            drain();
        end

        // SLICE == WIDTH: back-to-back with in_valid and out_ready held high
        begin
            int          last_acc;
            int          pend;
            logic        was_ready;
            logic [15:0] exp2;
            int          n_acc;
            int          n_res;
            last_acc = -1; pend = -10; exp2 = '0; n_acc = 0; n_res = 0;
            in_valid2 = 1'b1; out_ready2 = 1'b1;
            op2 = 3'b001; a2 = 16'h8000; b2 = 16'h0001;
            for (int cyc = 0; cyc < 24; cyc++) begin
                was_ready = in_ready2;
                tick();
                if (was_ready) begin
                    n_acc++;
                    if (last_acc >= 0) check("n1_accept_interval", 32'(cyc - last_acc), 32'd3);
                    last_acc = cyc;
                    pend = cyc;
                    exp2 = ref_op(op2, a2, b2);
                    op2 = 3'($urandom_range(0, 7));
                    a2 = 16'($urandom);
                    b2 = 16'($urandom);
                end
                if (out_valid2) begin
                    n_res++;
                    check("n1_valid_delay", 32'(cyc - pend), 32'd1);
                    check("n1_out", 32'(out2), 32'(exp2));
                    check("n1_neg", 32'(neg2), 32'(exp2[15]));
                    check("n1_zero", 32'(zero2), 32'(exp2 == 16'h0000));
                end
            end
            check("n1_accept_count", 32'(n_acc), 32'd8);
            check("n1_result_count", 32'(n_res), 32'd8);
        end
        in_valid2 = 1'b0; out_ready2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
